mem_stage_lsu: RTL and testbench

- Next-generation pipeline MEM stage: load/store unit plus MEM/WB pipeline register.
- Replaces the fixed single-cycle data memory with a req/gnt/rvalid data-memory port of variable latency.
- Supports byte/half/word (and doubleword when DAT_WIDTH=64) accesses, with byte enables and sign/zero extension.
- Asserts stall_M to the hazard unit while an access is outstanding; sits between EX/MEM register and WB stage.

---
 rtl/lsu_pkg.sv | 61 ++++++
 rtl/mem_stage_lsu_align.sv | 57 +++++
 rtl/mem_stage_lsu.sv | 154 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Optional misaligned-access trapping is enabled with LSU_MISALIGN_CHK_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic logic f3_ok(input logic [2:0] f3,
                                   input logic dw64);
        logic ok;
        unique case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            F3_D, F3_WU:                    ok = dw64;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] be_mask(input logic [1:0] size,
                                           input logic [2:0] lane);
        logic [7:0] m;
        unique case (size)
            2'd0: m = 8'h01;
            2'd1: m = 8'h03;
            2'd2: m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << lane;
    endfunction

    // Lane-shift the full read word down, then size/sign the result
    function automatic logic [63:0] load_extend(input logic [63:0] data,
                                                input logic [2:0]  lane,
                                                input logic [2:0]  f3);
        logic [63:0] sh;
        logic [63:0] r;
        sh = data >> {lane, 3'b000};
        unique case (f3)
            F3_B:    r = {{56{sh[7]}}, sh[7:0]};
            F3_H:    r = {{48{sh[15]}}, sh[15:0]};
            F3_W:    r = {{32{sh[31]}}, sh[31:0]};
            F3_BU:   r = {56'd0, sh[7:0]};
            F3_HU:   r = {48'd0, sh[15:0]};
            F3_WU:   r = {32'd0, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Lane select, byte enables, store positioning and load extension.
// LSU_MISALIGN_CHK_EN: reject misaligned ops instead of force-aligning.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DAT_WIDTH  = 32
) (
    input  logic [2:0]              funct3_i,
    input  logic [DAT_WIDTH-1:0]    addr_i,
    input  logic [DAT_WIDTH-1:0]    wdata_i,
    input  logic [DAT_WIDTH-1:0]    rdata_i,
    output logic                    reject_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DAT_WIDTH/8-1:0]  be_o,
    output logic [DAT_WIDTH-1:0]    wdata_o,
    output logic [DAT_WIDTH-1:0]    rdata_o
);

    localparam int BE_WIDTH = DAT_WIDTH / 8;
    localparam int LANE_W   = $clog2(BE_WIDTH);

    logic [1:0]            size;
    logic [2:0]            szm;
    logic [2:0]            lane_raw;
    logic [2:0]            lane;
    logic                  ok;
    logic [ADDR_WIDTH-1:0] a;

    assign size     = funct3_i[1:0];
    assign ok       = f3_ok(funct3_i, DAT_WIDTH == 64);
    assign lane_raw = 3'(addr_i[LANE_W-1:0]);

    always_comb begin
        unique case (size)
            2'd0: szm = 3'b000;
            2'd1: szm = 3'b001;
            2'd2: szm = 3'b011;
            default: szm = 3'b111;
        endcase
    end

`ifdef LSU_MISALIGN_CHK_EN
    assign lane     = lane_raw;
    assign reject_o = ~ok | (|(lane_raw & szm));
`else
    assign lane     = lane_raw & ~szm;
    assign reject_o = ~ok;
`endif

    assign a       = ADDR_WIDTH'(addr_i);
    assign addr_o  = {a[ADDR_WIDTH-1:LANE_W], LANE_W'(0)};
    assign be_o    = BE_WIDTH'(be_mask(size, lane));
    assign wdata_o = wdata_i << {lane, 3'b000};
    assign rdata_o = DAT_WIDTH'(load_extend(64'(rdata_i), lane, funct3_i));

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: req/gnt/rvalid data-memory FSM plus MEM/WB register.
// LSU_MISALIGN_CHK_EN: misaligned ops skip memory and flag misalign_W.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DAT_WIDTH  = 32,
    localparam int BE_WIDTH  = DAT_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_M,
    input  logic                  RegWrite_M,
    input  logic                  MemtoReg_M,
    input  logic                  MemRead_M,
    input  logic                  MemWrite_M,
    input  logic [2:0]            funct3_M,
    input  logic [4:0]            rd_M,
    input  logic [ADDR_WIDTH-1:0] PC_4M,
    input  logic [DAT_WIDTH-1:0]  ALU_result_M,
    input  logic [DAT_WIDTH-1:0]  wdata_M,
    output logic                  stall_M,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [BE_WIDTH-1:0]   dmem_be,
    output logic [DAT_WIDTH-1:0]  dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DAT_WIDTH-1:0]  dmem_rdata,
    output logic                  valid_W,
    output logic                  RegWrite_W,
    output logic                  MemtoReg_W,
    output logic [4:0]            rd_W,
    output logic [ADDR_WIDTH-1:0] PC_4W,
    output logic [DAT_WIDTH-1:0]  ALU_result_W,
    output logic [DAT_WIDTH-1:0]  rdata_W,
    output logic                  misalign_W
);

    lsu_state_e state_q, state_d;

    logic                  mem_rq, reject, mem_op;
    logic                  req, stall, rsp_fire, mis_d;
    logic [DAT_WIDTH-1:0]  ext;

    logic                  valid_q, rw_q, m2r_q, mis_q;
    logic [4:0]            rd_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DAT_WIDTH-1:0]  alu_q, rdata_q;

    lsu_align #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DAT_WIDTH (DAT_WIDTH)
    ) u_align (
        .funct3_i(funct3_M),
        .addr_i  (ALU_result_M),
        .wdata_i (wdata_M),
        .rdata_i (dmem_rdata),
        .reject_o(reject),
        .addr_o  (dmem_addr),
        .be_o    (dmem_be),
        .wdata_o (dmem_wdata),
        .rdata_o (ext)
    );

    assign mem_rq = valid_M & (MemRead_M | MemWrite_M);
    assign mem_op = mem_rq & ~reject;

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req   = mem_op;
                stall = mem_op;
                if (mem_op)
                    state_d = dmem_gnt ? WAIT_RSP : WAIT_GNT;
            end
            WAIT_GNT: begin
                req   = 1'b1;
                stall = 1'b1;
                if (dmem_gnt)
                    state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                stall = ~dmem_rvalid;
                if (dmem_rvalid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_fire = (state_q == WAIT_RSP) & dmem_rvalid;
    assign stall_M  = stall;
    assign dmem_req = req & rst_n;
    assign dmem_we  = MemWrite_M;

`ifdef LSU_MISALIGN_CHK_EN
    assign mis_d = mem_rq & reject;
`else
    assign mis_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stalled cycles drain a bubble; payload fields simply hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            mis_q   <= 1'b0;
            rd_q    <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (stall) begin
                valid_q <= 1'b0;
                rw_q    <= 1'b0;
                mis_q   <= 1'b0;
            end else begin
                valid_q <= valid_M;
                rw_q    <= valid_M & RegWrite_M & ~(mem_rq & reject);
                m2r_q   <= MemtoReg_M;
                mis_q   <= mis_d;
                rd_q    <= rd_M;
                pc_q    <= PC_4M;
                alu_q   <= ALU_result_M;
            end
            if (rsp_fire)
                rdata_q <= ext;
        end
    end

    assign valid_W      = valid_q;
    assign RegWrite_W   = rw_q;
    assign MemtoReg_W   = m2r_q;
    assign misalign_W   = mis_q;
    assign rd_W         = rd_q;
    assign PC_4W        = pc_q;
    assign ALU_result_W = alu_q;
    assign rdata_W      = rdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu (32-bit data).
// Honours LSU_MISALIGN_CHK_EN the same way as the RTL build.
module tb_mem_stage_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_M = 1'b0;
    logic        RegWrite_M = 1'b0;
    logic        MemtoReg_M = 1'b0;
    logic        MemRead_M = 1'b0;
    logic        MemWrite_M = 1'b0;
    logic [2:0]  funct3_M = '0;
    logic [4:0]  rd_M = '0;
    logic [31:0] PC_4M = '0;
    logic [31:0] ALU_result_M = '0;
    logic [31:0] wdata_M = '0;
    logic        stall_M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        valid_W, RegWrite_W, MemtoReg_W;
    logic [4:0]  rd_W;
    logic [31:0] PC_4W, ALU_result_W, rdata_W;
    logic        misalign_W;

    mem_stage_lsu #(.ADDR_WIDTH(32), .DAT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_M(valid_M),
        .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M),
        .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .funct3_M(funct3_M), .rd_M(rd_M), .PC_4M(PC_4M),
        .ALU_result_M(ALU_result_M), .wdata_M(wdata_M),
        .stall_M(stall_M), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .valid_W(valid_W), .RegWrite_W(RegWrite_W),
        .MemtoReg_W(MemtoReg_W), .rd_W(rd_W), .PC_4W(PC_4W),
        .ALU_result_W(ALU_result_W), .rdata_W(rdata_W),
        .misalign_W(misalign_W)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  kind;
        logic [31:0] data;
        logic        mis;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic [4:0] rd_n = 5'd1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Request monitor: every accepted request must match the next expected one
    always @(negedge clk) begin
        if (rst_n && dmem_req && dmem_gnt) begin
            if (req_q.size() == 0) begin
                chk("unexpected dmem request", 1, 0);
            end else begin
                req_t r;
                r = req_q.pop_front();
                chk("dmem_we", dmem_we, r.we);
                chk("dmem_addr", dmem_addr, r.addr);
                chk("dmem_be", dmem_be, r.be);
                if (r.we)
                    chk("dmem_wdata", dmem_wdata, r.wdata);
            end
        end
    end

    // WB monitor: each valid_W beat pops one expected retirement
    always @(negedge clk) begin
        if (valid_W) begin
            if (wb_q.size() == 0) begin
                chk("unexpected WB write", 1, 0);
            end else begin
                wb_t w;
                w = wb_q.pop_front();
                chk("RegWrite_W", RegWrite_W, w.rw);
                chk("rd_W", rd_W, w.rd);
                chk("misalign_W", misalign_W, w.mis);
                if (w.kind == 2'd1)
                    chk("rdata_W", rdata_W, w.data);
                if (w.kind == 2'd2)
                    chk("ALU_result_W", ALU_result_W, w.data);
            end
        end
    end

    task automatic idle_inputs();
        valid_M     = 1'b0;
        MemRead_M   = 1'b0;
        MemWrite_M  = 1'b0;
        RegWrite_M  = 1'b0;
        MemtoReg_M  = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    // gd: cycle of gnt, rv: cycle of rvalid (cycle 0 = first M cycle)
    task automatic op(input string nm, input logic rd_en,
                      input logic wr_en, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rdat, input int gd, input int rv,
                      input bit issues, input logic [31:0] e_addr,
                      input logic [3:0] e_be, input logic [31:0] e_wd,
                      input logic e_rw, input logic [1:0] kind,
                      input logic [31:0] e_data, input logic e_mis);
        int st = 0;
        int rq = 0;
        int bad = 0;
        bit done = 0;
        req_t r;
        wb_t  w;
        valid_M      = 1'b1;
        MemRead_M    = rd_en;
        MemWrite_M   = wr_en;
        RegWrite_M   = ~wr_en;
        MemtoReg_M   = rd_en;
        funct3_M     = f3;
        ALU_result_M = addr;
        wdata_M      = wd;
        rd_M         = rd_n;
        PC_4M        = addr + 32'd4;
        dmem_rdata   = rdat;
        dmem_gnt     = issues && (gd == 0);
        dmem_rvalid  = 1'b0;
        if (issues) begin
            r = '{we: wr_en, addr: e_addr, be: e_be, wdata: e_wd};
            req_q.push_back(r);
        end
        w = '{rw: e_rw, rd: rd_n, kind: kind, data: e_data, mis: e_mis};
        wb_q.push_back(w);
        rd_n = rd_n + 5'd1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall_M) st++;
            if (dmem_req) begin
                rq++;
                if (dmem_addr !== e_addr || dmem_be !== e_be) bad++;
            end
            done = !stall_M;
            @(posedge clk);
            #1;
            dmem_gnt    = issues && (c + 1 == gd);
            dmem_rvalid = issues && (c + 1 == rv);
        end
        idle_inputs();
        chk({nm, " completes"}, done, 1);
        chk({nm, " stall cycles"}, st, issues ? rv : 0);
        chk({nm, " req cycles"}, rq, issues ? gd + 1 : 0);
        chk({nm, " req stable"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("reset valid_W", valid_W, 0);
        chk("reset RegWrite_W", RegWrite_W, 0);
        chk("reset rdata_W", rdata_W, 0);
        chk("reset dmem_req", dmem_req, 0);
        chk("reset stall_M", stall_M, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        op("LW", 1, 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1,
           1, 32'h100, 4'hF, 32'h0, 1, 2'd1, 32'hDEADBEEF, 0);
        op("SB", 0, 1, F3_B, 32'h103, 32'hA5, 32'h0, 0, 1,
           1, 32'h100, 4'b1000, 32'hA500_0000, 0, 2'd0, 32'h0, 0);
        op("LB", 1, 0, F3_B, 32'h102, 32'h0, 32'h0080FF00, 0, 1,
           1, 32'h100, 4'b0100, 32'h0, 1, 2'd1, 32'hFFFFFF80, 0);
        op("LBU", 1, 0, F3_BU, 32'h102, 32'h0, 32'h0080FF00, 0, 1,
           1, 32'h100, 4'b0100, 32'h0, 1, 2'd1, 32'h00000080, 0);
        op("LH", 1, 0, F3_H, 32'h102, 32'h0, 32'h8001_0000, 0, 1,
           1, 32'h100, 4'b1100, 32'h0, 1, 2'd1, 32'hFFFF8001, 0);
        op("LHU", 1, 0, F3_HU, 32'h102, 32'h0, 32'h8001_0000, 0, 1,
           1, 32'h100, 4'b1100, 32'h0, 1, 2'd1, 32'h00008001, 0);
        op("SH", 0, 1, F3_H, 32'h102, 32'h0000BEEF, 32'h0, 0, 1,
           1, 32'h100, 4'b1100, 32'hBEEF_0000, 0, 2'd0, 32'h0, 0);
        op("LW slow", 1, 0, F3_W, 32'h200, 32'h0, 32'h12345678, 3, 5,
           1, 32'h200, 4'hF, 32'h0, 1, 2'd1, 32'h12345678, 0);
        op("ALU", 0, 0, F3_W, 32'h1234, 32'h0, 32'h0, 0, 0,
           0, 32'h1234, 4'hF, 32'h0, 1, 2'd2, 32'h1234, 0);
`ifdef LSU_MISALIGN_CHK_EN
        op("LW mis", 1, 0, F3_W, 32'h102, 32'h0, 32'hCAFEF00D, 0, 1,
           0, 32'h100, 4'hF, 32'h0, 0, 2'd0, 32'h0, 1);
`else
        op("LW forced", 1, 0, F3_W, 32'h102, 32'h0, 32'hCAFEF00D, 0, 1,
           1, 32'h100, 4'hF, 32'h0, 1, 2'd1, 32'hCAFEF00D, 0);
`endif
        @(posedge clk);
        #1;

        // Reset while waiting for the response, then a stray rvalid
        valid_M      = 1'b1;
        MemRead_M    = 1'b1;
        RegWrite_M   = 1'b1;
        MemtoReg_M   = 1'b1;
        funct3_M     = F3_W;
        ALU_result_M = 32'h300;
        dmem_gnt     = 1'b1;
        req_q.push_back('{we: 1'b0, addr: 32'h300, be: 4'hF, wdata: 32'h0});
        @(negedge clk);
        chk("rst test stall IDLE", stall_M, 1);
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        chk("rst test stall WAIT_RSP", stall_M, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst valid_W", valid_W, 0);
        chk("mid rst ALU_result_W", ALU_result_W, 0);
        chk("mid rst rdata_W", rdata_W, 0);
        chk("mid rst dmem_req", dmem_req, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55AA55AA;
        @(negedge clk);
        chk("stray rvalid stall", stall_M, 0);
        @(posedge clk);
        #1 dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("stray rvalid valid_W", valid_W, 0);
        chk("stray rvalid RegWrite_W", RegWrite_W, 0);
        chk("stray rvalid rdata_W", rdata_W, 0);

        repeat (3) @(posedge clk);
        chk("req queue drained", req_q.size(), 0);
        chk("wb queue drained", wb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
